// File: rtl/as_ifetch_pkg.sv
// Shared types and widths for the as_* rv64i core slice: fetch-queue entry and fetch FSM state.
package as_pack;

    localparam int imem_addr_width = 16;
    localparam int instr_width     = 32;
    localparam int pc_width        = 64;

    localparam logic [instr_width-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [instr_width-1:0] instr;
        logic [pc_width-1:0]    pc;
        logic                   fault;
    } fq_entry_t;

    typedef enum logic {
        IF_RUN,
        IF_HALT
    } ifetch_state_t;

endpackage

// File: rtl/as_ifetch_fetch_queue.sv
// Generic DEPTH-entry FIFO of fetch entries with push/pop/flush and occupancy count.
module as_fetch_queue
    import as_pack::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fq_entry_t        entry_i,
    output logic             valid_o,
    output fq_entry_t        entry_o,
    output logic [CNT_W-1:0] count_o
);

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop = pop_i && (r_count != '0);

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            r_mem[r_tail] <= entry_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({push_i, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid_o = (r_count != '0);
    assign entry_o = valid_o ? r_mem[r_head] : '0;
    assign count_o = r_count;

endmodule

// File: rtl/as_ifetch.sv
// Instruction-fetch stage: PC, fetch FSM and push decision feeding as_fetch_queue.
// Optional performance counters are enabled by defining AS_IFETCH_PERF_EN.
module as_ifetch
    import as_pack::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    output logic [imem_addr_width-1:0] imem_addr_o,
    input  logic [instr_width-1:0]     imem_data_i,
    input  logic                       redirect_i,
    input  logic [63:0]                redirect_pc_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [instr_width-1:0]     instr_o,
    output logic [63:0]                pc_o,
    output logic                       fault_o
`ifdef AS_IFETCH_PERF_EN
    ,
    output logic [63:0]                perf_fetched_o,
    output logic [63:0]                perf_flushed_o
`endif
);

    localparam int               CNT_W    = $clog2(FQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);

    ifetch_state_t    r_state;
    ifetch_state_t    w_state_next;
    logic [63:0]      r_pc;
    logic [CNT_W-1:0] w_count;
    logic             w_pop;
    logic             w_push;
    logic             w_misaligned;
    fq_entry_t        w_entry_in;
    fq_entry_t        w_entry_out;

    assign w_pop        = valid_o && ready_i;
    assign w_misaligned = (r_pc[1:0] != 2'b00);
    // A full queue can still accept a push in the same cycle its head is popped.
    assign w_push       = (r_state == IF_RUN) && !redirect_i && ((w_count < FULL_CNT) || w_pop);

    always_comb begin
        w_entry_in.pc = r_pc;
        if (w_misaligned) begin
            w_entry_in.instr = NOP_INSTR;
            w_entry_in.fault = 1'b1;
        end else begin
            w_entry_in.instr = imem_data_i;
            w_entry_in.fault = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IF_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_i) begin
            w_state_next = IF_RUN;
        end else if (w_push && w_misaligned) begin
            w_state_next = IF_HALT;
        end
    end

    // The PC is held on a misaligned fetch so the fault entry carries the bad target.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= redirect_pc_i;
        end else if (w_push && !w_misaligned) begin
            r_pc <= r_pc + 64'd4;
        end
    end

    as_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .entry_i (w_entry_in),
        .valid_o (valid_o),
        .entry_o (w_entry_out),
        .count_o (w_count)
    );

    assign imem_addr_o = r_pc[imem_addr_width-1:0];
    assign instr_o     = w_entry_out.instr;
    assign pc_o        = w_entry_out.pc;
    assign fault_o     = w_entry_out.fault;

`ifdef AS_IFETCH_PERF_EN
    logic [63:0] r_perf_fetched;
    logic [63:0] r_perf_flushed;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 64'd1;
            end
            if (redirect_i) begin
                r_perf_flushed <= r_perf_flushed + 64'(w_count);
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_flushed_o = r_perf_flushed;
`endif

endmodule

// File: tb/tb_as_ifetch.sv
// Self-checking bench for as_ifetch: directed scenarios then random traffic against a queue-based model.
module tb_as_ifetch;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          FQ_DEPTH = 2;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        fault;
    } ent_t;

    logic        clk_i;
    logic        rstn_i;
    logic [15:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        fault_o;
`ifdef AS_IFETCH_PERF_EN
    logic [63:0] perf_fetched_o;
    logic [63:0] perf_flushed_o;
`endif

    logic [31:0] mem [16384];

    ent_t        mq[$];
    logic [63:0] m_pc;
    logic        m_halt;
    logic [63:0] m_fetched;
    logic [63:0] m_flushed;

    int checks;
    int errors;

    as_ifetch #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o)
`ifdef AS_IFETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched_o),
        .perf_flushed_o (perf_flushed_o)
`endif
    );

    assign imem_data_i = mem[imem_addr_o[15:2]];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_pc      = RESET_PC;
        m_halt    = 1'b0;
        m_fetched = '0;
        m_flushed = '0;
    endtask

    task automatic checkOutput();
        ent_t head;
        head = '{instr: 32'h0, pc: 64'h0, fault: 1'b0};
        if (mq.size() > 0) head = mq[0];
        check("valid_o",     64'(valid_o),     64'(mq.size() > 0));
        check("instr_o",     64'(instr_o),     64'(head.instr));
        check("pc_o",        pc_o,             head.pc);
        check("fault_o",     64'(fault_o),     64'(head.fault));
        check("imem_addr_o", 64'(imem_addr_o), 64'(m_pc[15:0]));
`ifdef AS_IFETCH_PERF_EN
        check("perf_fetched_o", perf_fetched_o, m_fetched);
        check("perf_flushed_o", perf_flushed_o, m_flushed);
`endif
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, sample 1 time unit after the edge.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [63:0] rpc);
        int   sz;
        logic pop;
        logic canpush;
        ready_i       = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        sz  = mq.size();
        pop = (sz > 0) && rdy;
        if (redir) begin
            m_flushed = m_flushed + 64'(sz);
            mq.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            canpush = !m_halt && ((sz < FQ_DEPTH) || pop);
            if (pop) mq.delete(0);
            if (canpush) begin
                if (m_pc[1:0] != 2'b00) begin
                    mq.push_back('{instr: 32'h0000_0013, pc: m_pc, fault: 1'b1});
                    m_halt = 1'b1;
                end else begin
                    mq.push_back('{instr: mem[m_pc[15:2]], pc: m_pc, fault: 1'b0});
                    m_pc = m_pc + 64'd4;
                end
                m_fetched = m_fetched + 64'd1;
            end
        end
        @(posedge clk_i);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [63:0] rpc;
        checks        = 0;
        errors        = 0;
        rstn_i        = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00C0_0193;
        modelReset();

        #12;
        checkOutput();
        rstn_i = 1'b1;
        #1;
        checkOutput();

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);

        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 64'h40);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

        applyStimulus(1'b1, 1'b1, 64'h42);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 64'h80);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

        applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 64'h100);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);

        #2;
        rstn_i = 1'b0;
        #1;
        modelReset();
        checkOutput();
        #3;
        rstn_i = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            rpc = {48'h0, 16'($urandom_range(0, 16383) * 4)};
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rpc[63:16] = 48'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/as_ifetch.md
Name: as_ifetch

Overview:
- Instruction-fetch stage of the rv64i core. It sits directly upstream of as_imem and downstream-feeds decode.
- Holds the PC, drives the instruction-memory read address, and captures the combinational read data together with its PC.
- Buffers fetched instructions in a small FIFO with a valid/ready handshake to decode.
- Handles redirects (branch/jump/trap) with a flush, and flags misaligned fetch targets.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset; must be 4-byte aligned.
- FQ_DEPTH, 2, fetch-queue entries; power of two, 2..8.

Ports:
- clk_i  in  1  core clock; all state on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- imem_addr_o  out  imem_addr_width  byte address to as_imem; equals pc_q[imem_addr_width-1:0].
- imem_data_i  in  instr_width  combinational read data from as_imem, same cycle as imem_addr_o.
- redirect_i  in  1  redirect request from execute/trap logic.
- redirect_pc_i  in  64  redirect target.
- valid_o  out  1  queue head valid.
- ready_i  in  1  decode accepts head.
- instr_o  out  instr_width  head instruction.
- pc_o  out  64  head PC.
- fault_o  out  1  head entry is a misaligned-fetch fault.

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, queue empty, state=RUN. valid_o=0, instr_o=0, pc_o=0, fault_o=0.
- States:
  - RUN: fetch one word per cycle.
  - HALT: no fetch; entered after a fault entry is pushed; left only by redirect_i.
- pop = valid_o & ready_i.
- push: occurs when state=RUN, !redirect_i, and (count<FQ_DEPTH or pop). Full-with-pop is a legal simultaneous push/pop.
- push effect: the entry {instr=imem_data_i, pc=pc_q, fault=0} is written at the tail, and pc_q <= pc_q+4. PC add is 64-bit and wraps modulo 2^64.
- Misaligned PC (pc_q[1:0]!=0) in RUN: push an entry {instr=32'h0000_0013 (NOP), pc=pc_q, fault=1} instead; pc_q is held; next state HALT.
- redirect_i=1:
  - Queue cleared (count=0), overriding any same-cycle pop or push.
  - pc_q <= redirect_pc_i; state <= RUN.
  - valid_o is 0 from the next cycle until a new push.
  - Redirect during HALT resumes fetch.
- Load latency: imem read is combinational, so a pushed entry is visible on valid_o the cycle after the push.
- Empty queue: valid_o=0; instr_o/pc_o/fault_o are driven 0, never stale data.
- Ordering: the FIFO preserves PC order. head/tail pointers wrap modulo FQ_DEPTH; count ranges 0..FQ_DEPTH.
- Outputs come from registered queue storage; there is no combinational path from ready_i to valid_o.
- Reset asserted mid-operation discards the queue immediately and restarts at RESET_PC.

Optional Feature:
- Macro: AS_IFETCH_PERF_EN.
- Defined: two 64-bit counters plus output ports.
  - perf_fetched_o: increments on each push.
  - perf_flushed_o: increments by count on redirect when count>0.
  - Both reset to 0 and wrap at 2^64.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- as_pack gains:
  - pc_width=64.
  - NOP_INSTR=32'h0000_0013.
  - typedef fq_entry_t {logic [instr_width-1:0] instr; logic [pc_width-1:0] pc; logic fault;}.
  - typedef enum {IF_RUN, IF_HALT} ifetch_state_t.
- Reuses existing imem_addr_width and instr_width.
- One sub-module: as_fetch_queue, a generic FQ_DEPTH FIFO of fq_entry_t with push/pop/flush/count.
- as_ifetch holds the PC, the FSM and the push decision.

Test Plan:
- Reset with RESET_PC=0, ready_i=1, imem preloaded with 0x00500113, 0x00C00193 at words 0 and 1. Expect imem_addr_o 0x0, then 0x4. Expect valid_o=1 with pc_o=0/instr_o=0x00500113 in cycle 1, then pc_o=4/instr_o=0x00C00193.
- Backpressure, ready_i=0 for 5 cycles. Expect exactly FQ_DEPTH=2 pushes and pc_q=0x8 held. Releasing ready_i delivers PCs 0, 4, 8 in order with no loss or duplication.
- Queue full plus ready_i=1 in the same cycle. Expect simultaneous pop and push, and count stays 2.
- redirect_i=1 with redirect_pc_i=0x40 while the queue holds 2 entries and ready_i=1. Expect valid_o=0 next cycle, then pc_o=0x40.
- redirect_pc_i=0x42. Expect one entry with fault_o=1, pc_o=0x42, instr_o=0x00000013, then no further valid_o. A later redirect to 0x80 resumes fetch at 0x80.
- rstn_i pulsed low mid-stream, asynchronous to clk_i. Expect valid_o=0 immediately and fetch restarting at RESET_PC. With AS_IFETCH_PERF_EN defined, expect perf_fetched_o=0 and perf_flushed_o=0 after reset, and perf_flushed_o+=2 on a redirect with 2 queued entries.
